// File: rtl/distance_trigger_pkg.sv
// Shared state encoding, counter types and default timing for the distance
// trigger and the echo measurement logic that reuses it.
package distance_trigger_pkg;

    // Defaults assume a 125 MHz clock: 10 us trigger, 60 ms period, 38 ms echo limit.
    localparam int DEF_T_TRIG    = 1250;
    localparam int DEF_T_PERIOD  = 7500000;
    localparam int DEF_T_TIMEOUT = 4750000;

    localparam int PERIOD_CNT_W  = 23;
    localparam int WAIT_CNT_W    = 23;

    typedef logic [PERIOD_CNT_W-1:0] period_cnt_t;
    typedef logic [WAIT_CNT_W-1:0]   wait_cnt_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        HOLDOFF   = 3'd4
    } trig_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous line, with rise/fall pulses taken
// from the synchronized value against one further registered copy.
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/distance_trigger.sv
// Ultrasonic ranging controller: issues a timed trigger pulse, then waits for a
// complete echo rise/fall within a timeout, spacing triggers by a minimum period.
module distance_trigger
    import distance_trigger_pkg::*;
#(
    parameter int T_TRIG    = DEF_T_TRIG,
    parameter int T_PERIOD  = DEF_T_PERIOD,
    parameter int T_TIMEOUT = DEF_T_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic start,
    input  logic echo_in,
    output logic trig_out,
    output logic busy,
    output logic done,
    output logic timeout
);

    localparam wait_cnt_t   TRIG_LAST    = wait_cnt_t'(T_TRIG - 1);
    localparam wait_cnt_t   TIMEOUT_LAST = wait_cnt_t'(T_TIMEOUT - 1);
    localparam period_cnt_t PERIOD_MAX   = period_cnt_t'(T_PERIOD);
    localparam period_cnt_t PERIOD_LAST  = period_cnt_t'(T_PERIOD - 1);

    trig_state_e state_q, state_d;
    wait_cnt_t   phaseCnt_q, phaseCnt_d;
    period_cnt_t periodCnt_q, periodCnt_d;
    logic        trig_q, trig_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    logic        echoRise;
    logic        echoFall;
    logic        trigRise;
    logic        periodReached;

    sync_edge u_echoSync (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .async_i (echo_in),
        .rise_o  (echoRise),
        .fall_o  (echoFall)
    );

    // The counter lands on T_PERIOD at the coming edge, so leaving HOLDOFF now
    // makes the next trigger rise exactly T_PERIOD cycles after the previous one.
    assign periodReached = (periodCnt_q >= PERIOD_LAST);

    always_comb begin
        state_d    = state_q;
        phaseCnt_d = '0;
        done_d     = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable || start) begin
                    state_d = TRIG;
                end
            end

            TRIG: begin
                phaseCnt_d = phaseCnt_q + wait_cnt_t'(1);
                if (phaseCnt_q == TRIG_LAST) begin
                    state_d    = WAIT_RISE;
                    phaseCnt_d = '0;
                end
            end

            WAIT_RISE: begin
                phaseCnt_d = phaseCnt_q + wait_cnt_t'(1);
                if (echoRise) begin
                    state_d    = WAIT_FALL;
                    phaseCnt_d = '0;
                end else if (phaseCnt_q == TIMEOUT_LAST) begin
                    state_d    = HOLDOFF;
                    phaseCnt_d = '0;
                    timeout_d  = 1'b1;
                end
            end

            // A falling edge arriving on the last allowed cycle still counts as a hit.
            WAIT_FALL: begin
                phaseCnt_d = phaseCnt_q + wait_cnt_t'(1);
                if (echoFall) begin
                    state_d    = HOLDOFF;
                    phaseCnt_d = '0;
                    done_d     = 1'b1;
                end else if (phaseCnt_q == TIMEOUT_LAST) begin
                    state_d    = HOLDOFF;
                    phaseCnt_d = '0;
                    timeout_d  = 1'b1;
                end
            end

            HOLDOFF: begin
                if (periodReached) begin
                    state_d = enable ? TRIG : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign trig_d   = (state_d == TRIG);
    assign trigRise = trig_d & ~trig_q;

    always_comb begin
        periodCnt_d = periodCnt_q;
        if (trigRise) begin
            periodCnt_d = '0;
        end else if (periodCnt_q < PERIOD_MAX) begin
            periodCnt_d = periodCnt_q + period_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phaseCnt_q  <= '0;
            periodCnt_q <= '0;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phaseCnt_q  <= phaseCnt_d;
            periodCnt_q <= periodCnt_d;
            trig_q      <= trig_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign trig_out = trig_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_distance_trigger.sv
// Bench for distance_trigger: timestamp-based reference model compared every
// cycle, directed timing scenarios with literal expectations, then random traffic.
module tb_distance_trigger;

    localparam int T_TRIG    = 4;
    localparam int T_PERIOD  = 40;
    localparam int T_TIMEOUT = 20;

    localparam int C_RISE     = 0;
    localparam int C_FALL     = 1;
    localparam int C_DONE     = 2;
    localparam int C_TIMEOUT  = 3;
    localparam int C_BUSYFALL = 4;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic enable  = 1'b0;
    logic start   = 1'b0;
    logic echo_in = 1'b0;
    logic trig_out;
    logic busy;
    logic done;
    logic timeout;

    int assertCount = 0;
    int failCount   = 0;

    distance_trigger #(
        .T_TRIG    (T_TRIG),
        .T_PERIOD  (T_PERIOD),
        .T_TIMEOUT (T_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .start    (start),
        .echo_in  (echo_in),
        .trig_out (trig_out),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic st, input logic echo);
        enable  = en;
        start   = st;
        echo_in = echo;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference model: a measurement is described by the edge index of its
    // trigger rise and of the current echo-wait start; outputs follow by arithmetic.
    logic       expTrig    = 1'b0;
    logic       expBusy    = 1'b0;
    logic       expDone    = 1'b0;
    logic       expTimeout = 1'b0;
    int         mEdge      = 0;
    int         mRise      = 0;
    int         mPhase     = 0;
    bit         mMeas      = 1'b0;
    bit         mHold      = 1'b0;
    bit         mGotRise   = 1'b0;
    logic [2:0] mEcho      = 3'b000;

    task automatic modelFinish(input bit isDone);
        mMeas      = 1'b0;
        mHold      = 1'b1;
        expDone    = isDone;
        expTimeout = !isDone;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mMeas = 1'b0; mHold = 1'b0; mGotRise = 1'b0; mEcho = 3'b000;
            expTrig = 1'b0; expBusy = 1'b0; expDone = 1'b0; expTimeout = 1'b0;
        end else begin
            bit echoRise;
            bit echoFall;
            mEdge++;
            echoRise   = mEcho[1] && !mEcho[2];
            echoFall   = !mEcho[1] && mEcho[2];
            expDone    = 1'b0;
            expTimeout = 1'b0;
            if (mMeas) begin
                if (mEdge - mRise == T_TRIG) begin
                    mPhase   = mEdge;
                    mGotRise = 1'b0;
                end else if (mEdge - mRise > T_TRIG) begin
                    if (!mGotRise && echoRise) begin
                        mGotRise = 1'b1;
                        mPhase   = mEdge;
                    end else if (mGotRise && echoFall) begin
                        modelFinish(1'b1);
                    end else if (mEdge - mPhase == T_TIMEOUT) begin
                        modelFinish(1'b0);
                    end
                end
            end else if (mHold) begin
                if (mEdge - mRise >= T_PERIOD) begin
                    mHold = 1'b0;
                    if (enable) begin
                        mMeas = 1'b1;
                        mRise = mEdge;
                    end
                end
            end else if (enable || start) begin
                mMeas = 1'b1;
                mRise = mEdge;
            end
            expTrig = mMeas && (mEdge - mRise < T_TRIG);
            expBusy = mMeas || mHold;
            mEcho   = {mEcho[1:0], echo_in};
        end
    end

    initial forever begin
        @(negedge clk);
        checkOutput("trig_out", trig_out, expTrig);
        checkOutput("busy", busy, expBusy);
        checkOutput("done", done, expDone);
        checkOutput("timeout", timeout, expTimeout);
    end

    // Event monitor used by the directed timing checks.
    int cyc = 0;
    int riseCount = 0, fallCount = 0, doneCount = 0, timeoutCount = 0, busyFallCount = 0;
    int lastRiseCyc = 0, spacing = 0, highLen = 0, lastHighLen = 0;
    int fallCyc = 0, doneCyc = 0, timeoutCyc = 0, busyFallCyc = 0;
    logic prevTrig = 1'b0;
    logic prevBusy = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prevTrig = 1'b0;
            prevBusy = 1'b0;
        end else begin
            if (trig_out && !prevTrig) begin
                riseCount++;
                spacing     = cyc - lastRiseCyc;
                lastRiseCyc = cyc;
                highLen     = 0;
            end
            if (trig_out) highLen++;
            if (!trig_out && prevTrig) begin
                fallCount++;
                lastHighLen = highLen;
                fallCyc     = cyc;
            end
            if (done) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (timeout) begin
                timeoutCount++;
                timeoutCyc = cyc;
            end
            if (!busy && prevBusy) begin
                busyFallCount++;
                busyFallCyc = cyc;
            end
            prevTrig = trig_out;
            prevBusy = busy;
        end
    end

    function automatic int getCount(input int which);
        case (which)
            C_RISE:    return riseCount;
            C_FALL:    return fallCount;
            C_DONE:    return doneCount;
            C_TIMEOUT: return timeoutCount;
            default:   return busyFallCount;
        endcase
    endfunction

    task automatic waitUntil(input string name, input int which, input int target, input int limit);
        int k = 0;
        while (getCount(which) < target && k < limit) begin
            step();
            k++;
        end
        checkOutput(name, int'(getCount(which) >= target), 1);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int rBase, dBase, tBase, bBase, fBase, relCyc, togDiv;
        logic rEn, rEcho;

        applyStimulus(1'b0, 1'b0, 1'b0);
        resetDut();
        checkOutput("reset_trig", trig_out, 0);
        checkOutput("reset_busy", busy, 0);

        // Periodic mode with a 10-cycle echo.
        rBase = riseCount; dBase = doneCount; tBase = timeoutCount; fBase = fallCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil("A_trigFall", C_FALL, fBase + 1, 20);
        repeat (3) step();
        echo_in = 1'b1;
        repeat (10) step();
        echo_in = 1'b0;
        waitUntil("A_secondTrig", C_RISE, rBase + 2, 60);
        checkOutput("A_trigHigh", lastHighLen, 4);
        checkOutput("A_spacing", spacing, 40);
        checkOutput("A_doneCount", doneCount - dBase, 1);
        checkOutput("A_noTimeout", timeoutCount - tBase, 0);

        // Periodic mode with no echo at all.
        rBase = riseCount; dBase = doneCount; tBase = timeoutCount;
        waitUntil("B_timeoutSeen", C_TIMEOUT, tBase + 1, 40);
        checkOutput("B_timeoutDelay", timeoutCyc - fallCyc, 20);
        waitUntil("B_nextTrig", C_RISE, rBase + 1, 40);
        checkOutput("B_spacing", spacing, 40);
        checkOutput("B_noDone", doneCount - dBase, 0);

        // Enable dropped mid-trigger: cycle completes, then idles at period end.
        tBase = timeoutCount; bBase = busyFallCount;
        enable = 1'b0;
        waitUntil("C_busyFall", C_BUSYFALL, bBase + 1, 60);
        checkOutput("C_trigNotAborted", lastHighLen, 4);
        checkOutput("C_timeoutCount", timeoutCount - tBase, 1);
        checkOutput("C_idleAtPeriod", busyFallCyc - lastRiseCyc, 40);

        // Single shot via start, with a start pulse ignored during WAIT_FALL.
        rBase = riseCount; dBase = doneCount; tBase = timeoutCount; bBase = busyFallCount; fBase = fallCount;
        applyStimulus(1'b0, 1'b1, 1'b0);
        step();
        start = 1'b0;
        waitUntil("D_trigFall", C_FALL, fBase + 1, 20);
        repeat (3) step();
        echo_in = 1'b1;
        repeat (5) step();
        echo_in = 1'b0;
        start   = 1'b1;
        step();
        start   = 1'b0;
        waitUntil("D_busyFall", C_BUSYFALL, bBase + 1, 60);
        repeat (50) step();
        checkOutput("D_singleTrig", riseCount - rBase, 1);
        checkOutput("D_doneCount", doneCount - dBase, 1);
        checkOutput("D_noTimeout", timeoutCount - tBase, 0);
        checkOutput("D_busyEnd", busyFallCyc - lastRiseCyc, 40);
        checkOutput("D_idleBusy", busy, 0);

        // Echo falls on the very last allowed WAIT_FALL cycle.
        rBase = riseCount; dBase = doneCount; tBase = timeoutCount; bBase = busyFallCount; fBase = fallCount;
        applyStimulus(1'b0, 1'b1, 1'b0);
        step();
        start = 1'b0;
        waitUntil("E_trigFall", C_FALL, fBase + 1, 20);
        repeat (3) step();
        echo_in = 1'b1;
        repeat (20) step();
        echo_in = 1'b0;
        waitUntil("E_busyFall", C_BUSYFALL, bBase + 1, 80);
        checkOutput("E_doneWins", doneCount - dBase, 1);
        checkOutput("E_noTimeout", timeoutCount - tBase, 0);
        checkOutput("E_doneCycle", doneCyc - fallCyc, 26);

        // Reset pulse in the middle of a trigger.
        rBase = riseCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil("F_trigRise", C_RISE, rBase + 1, 5);
        rBase = riseCount;
        step();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("F_trigAsync", trig_out, 0);
        checkOutput("F_busyAsync", busy, 0);
        checkOutput("F_doneAsync", done, 0);
        checkOutput("F_timeoutAsync", timeout, 0);
        step();
        rst_n  = 1'b1;
        relCyc = cyc;
        waitUntil("F_retrig", C_RISE, rBase + 1, 5);
        checkOutput("F_retrigDelay", lastRiseCyc - relCyc, 1);

        // Random traffic, checked cycle by cycle against the model.
        rEn = 1'b1;
        rEcho = 1'b0;
        for (int seg = 0; seg < 15; seg++) begin
            togDiv = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 8 : 40);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(togDiv - 1) == 0) rEcho = ~rEcho;
                if ($urandom_range(79) == 0) rEn = ~rEn;
                applyStimulus(rEn, ($urandom_range(11) == 0), rEcho);
                if ($urandom_range(699) == 0) begin
                    rst_n = 1'b0;
                    step();
                    rst_n = 1'b1;
                end
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
